// File: rtl/bht_update_ctrl_if.sv
// BHT update-port bundle: the controller (master) offers one row update per
// beat and the BHT (slave) accepts it with upd_ready_i.
interface bht_update_ctrl_if #(
    parameter int IDX_W = 9
);
    logic             upd_valid_o;
    logic [IDX_W-1:0] upd_index_o;
    logic             upd_taken_o;
    logic             upd_clear_o;
    logic             upd_ready_i;

    modport master (
        output upd_valid_o,
        output upd_index_o,
        output upd_taken_o,
        output upd_clear_o,
        input  upd_ready_i
    );

    modport slave (
        input  upd_valid_o,
        input  upd_index_o,
        input  upd_taken_o,
        input  upd_clear_o,
        output upd_ready_i
    );
endinterface

// File: rtl/bht_update_ctrl.sv
// BHT write-port sequencer: arbitrates a row-clear engine against a FIFO of
// branch resolutions. Optional statistics counters under BHT_UPD_STATS_EN.
module bht_update_ctrl #(
    parameter int VLEN       = 39,
    parameter int NR_ROWS    = 512,
    parameter int IDX_LSB    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = $clog2(NR_ROWS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_bp_i,
    input  logic                   resolve_valid_i,
    input  logic [VLEN-1:0]        resolve_pc_i,
    input  logic                   resolve_taken_i,
    output logic                   resolve_ready_o,
    bht_update_ctrl_if.master      upd,
    output logic                   busy_o
`ifdef BHT_UPD_STATS_EN
    ,
    output logic [31:0]            stat_updates_o,
    output logic [31:0]            stat_stall_o
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_clr_cnt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_idx_mem [FIFO_DEPTH];
    logic               r_tkn_mem [FIFO_DEPTH];

    logic w_in_clear;
    logic w_head_vld;
    logic w_fire;
    logic w_push;
    logic w_pop;
    logic w_unused_pc;

    assign w_in_clear  = (r_state == CLEAR);
    assign w_head_vld  = (r_count != '0);
    assign w_unused_pc = ^resolve_pc_i;

    assign resolve_ready_o = (r_count < CNT_W'(FIFO_DEPTH)) & ~rst_i;

    // Queued resolutions wait behind the clear engine; only IDLE exposes the head.
    assign upd.upd_valid_o = ~rst_i & (w_in_clear | w_head_vld);
    assign upd.upd_clear_o = ~rst_i & w_in_clear;
    assign upd.upd_index_o = w_in_clear ? r_clr_cnt :
                             (w_head_vld ? r_idx_mem[r_rd_ptr] : '0);
    assign upd.upd_taken_o = ~w_in_clear & w_head_vld & r_tkn_mem[r_rd_ptr];
    assign busy_o          = w_in_clear;

    assign w_fire = upd.upd_valid_o & upd.upd_ready_i;
    assign w_push = resolve_valid_i & resolve_ready_o;
    assign w_pop  = w_fire & ~w_in_clear;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else if (flush_bp_i) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_in_clear && w_fire) begin
                if (r_clr_cnt == IDX_W'(NR_ROWS - 1)) begin
                    r_state   <= IDLE;
                    r_clr_cnt <= '0;
                end else begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage is never reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_idx_mem[r_wr_ptr] <= resolve_pc_i[IDX_LSB +: IDX_W];
            r_tkn_mem[r_wr_ptr] <= resolve_taken_i;
        end
    end

`ifdef BHT_UPD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_stat_upd;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_upd   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_fire && !upd.upd_clear_o) r_stat_upd <= sat_inc(r_stat_upd);
            if (resolve_valid_i && !resolve_ready_o) r_stat_stall <= sat_inc(r_stat_stall);
        end
    end

    assign stat_updates_o = r_stat_upd;
    assign stat_stall_o   = r_stat_stall;
`endif
endmodule
